// File: rtl/shreg_pkg.sv
// -----------------------------------------------------------------------------
// shreg_pkg
// Shared types and constants for the param_shift_reg serialiser/deserialiser.
//   mode_e  : operation select (HOLD, SHL, SHR, LOAD)
//   MODE_W  : width of the mode field
// -----------------------------------------------------------------------------
package shreg_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        HOLD = 2'b00,
        SHL  = 2'b01,
        SHR  = 2'b10,
        LOAD = 2'b11
    } mode_e;

    // Width of a counter able to hold the values 0..width inclusive.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage : shreg_pkg

// File: rtl/shift_cnt.sv
// -----------------------------------------------------------------------------
// shift_cnt
// Saturating shift counter and done-pulse generator. Counts shifts since the
// last clear; done pulses for one cycle when the count reaches WIDTH and never
// repeats until the counter is cleared again.
// Parameters:
//   WIDTH    number of shifts that make up a full word
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset (count=0, done=0)
//   inc      one shift executed this cycle
//   clr      clear counter (parallel load); has priority over inc
//   done     registered one-cycle pulse after the WIDTH-th shift
// -----------------------------------------------------------------------------
module shift_cnt
    import shreg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic inc,
    input  logic clr,
    output logic done
);

    localparam int                CNT_W   = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_PRE = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             done_r;
    logic             done_nxt_s;

    // Next count and done pulse: saturate at WIDTH, pulse only on the last step.
    always_comb begin
        cnt_nxt_s  = cnt_r;
        done_nxt_s = 1'b0;
        if (clr) begin
            cnt_nxt_s  = {CNT_W{1'b0}};
            done_nxt_s = 1'b0;
        end else if (inc) begin
            if (cnt_r != CNT_MAX) begin
                cnt_nxt_s  = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                done_nxt_s = (cnt_r == CNT_PRE);
            end else begin
                cnt_nxt_s  = cnt_r;
                done_nxt_s = 1'b0;
            end
        end else begin
            cnt_nxt_s  = cnt_r;
            done_nxt_s = 1'b0;
        end
    end

    // Counter and done register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r  <= {CNT_W{1'b0}};
            done_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_nxt_s;
            done_r <= done_nxt_s;
        end
    end

    assign done = done_r;

endmodule : shift_cnt

// File: rtl/param_shift_reg.sv
// -----------------------------------------------------------------------------
// param_shift_reg
// WIDTH-bit register with hold, parallel load and left/right serial shift.
// A shift counter flags (done) when a full word has been shifted since the
// last LOAD or reset.
// Build option: define SHREG_ROTATE_EN to add the rot port; with rot=1 the
// shifts feed back the outgoing bit instead of d.
// Parameters:
//   WIDTH      register width (>= 2)
//   RESET_VAL  value of q during reset
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   en         1 = execute mode this cycle, 0 = hold everything
//   mode       HOLD=00, SHL=01, SHR=10, LOAD=11
//   d          serial input bit
//   d_par      parallel load data
//   rot        rotate select (SHREG_ROTATE_EN only)
//   q          register contents
//   ser_out_l  q[WIDTH-1]
//   ser_out_r  q[0]
//   done       one-cycle pulse after the WIDTH-th shift
// -----------------------------------------------------------------------------
module param_shift_reg
    import shreg_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic              d,
    input  logic [WIDTH-1:0]  d_par,
`ifdef SHREG_ROTATE_EN
    input  logic              rot,
`endif
    output logic [WIDTH-1:0]  q,
    output logic              ser_out_l,
    output logic              ser_out_r,
    output logic              done
);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_nxt_s;
    logic             fill_l_s;
    logic             fill_r_s;
    logic             inc_s;
    logic             clr_s;
    mode_e            mode_s;

    assign mode_s = mode_e'(mode);

`ifdef SHREG_ROTATE_EN
    // SHL brings in from the right, so rotating feeds back the MSB; SHR the LSB.
    assign fill_l_s = rot ? q_r[WIDTH-1] : d;
    assign fill_r_s = rot ? q_r[0]       : d;
`else
    assign fill_l_s = d;
    assign fill_r_s = d;
`endif

    // Next-state mux and counter controls.
    always_comb begin
        q_nxt_s = q_r;
        inc_s   = 1'b0;
        clr_s   = 1'b0;
        if (en) begin
            case (mode_s)
                HOLD: begin
                    q_nxt_s = q_r;
                end
                SHL: begin
                    q_nxt_s = {q_r[WIDTH-2:0], fill_l_s};
                    inc_s   = 1'b1;
                end
                SHR: begin
                    q_nxt_s = {fill_r_s, q_r[WIDTH-1:1]};
                    inc_s   = 1'b1;
                end
                LOAD: begin
                    q_nxt_s = d_par;
                    clr_s   = 1'b1;
                end
                default: begin
                    q_nxt_s = q_r;
                end
            endcase
        end else begin
            q_nxt_s = q_r;
        end
    end

    // Data register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_r <= RESET_VAL;
        end else begin
            q_r <= q_nxt_s;
        end
    end

    shift_cnt #(
        .WIDTH (WIDTH)
    ) u_shift_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (inc_s),
        .clr     (clr_s),
        .done    (done)
    );

    assign q         = q_r;
    assign ser_out_l = q_r[WIDTH-1];
    assign ser_out_r = q_r[0];

endmodule : param_shift_reg
